// File: rtl/branch_predictor_bht.sv
// Branch history table: decodes conditional branches in IF, looks up a saturating counter by PC (bimodal or gshare), trained from EX.
// Latency: lookup is combinational (zero cycles); updates land on the next rising edge, with no bypass to a same-cycle lookup.
// Backpressure: none; a lookup is valid every cycle and at most one update is accepted per cycle.
module branch_predictor_bht #(
    parameter int PC_W       = 32,
    parameter int IDX_W      = 4,
    parameter int CTR_BITS   = 2,
    parameter int INIT_STATE = 1,
    parameter int MODE       = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          opcode,
    input  logic [PC_W-1:0]     pc,
    output logic                branch,
    output logic [CTR_BITS-1:0] taken,
    output logic                pred_taken,
    output logic [PC_W-1:0]     b_pc,
    output logic [IDX_W-1:0]    ghr,
    input  logic                upd_valid,
    input  logic [PC_W-1:0]     upd_pc,
    input  logic [IDX_W-1:0]    upd_ghr,
    input  logic                upd_taken,
    input  logic                upd_mispredict,
    output logic [31:0]         br_count,
    output logic [31:0]         mis_count
);

    localparam int                  ENTRIES   = 1 << IDX_W;
    localparam logic [CTR_BITS-1:0] CTR_MAX   = '1;
    localparam logic [CTR_BITS-1:0] CTR_INIT  = CTR_BITS'(INIT_STATE);
    localparam logic [6:0]          OP_BRANCH = 7'b1100011;

    logic [CTR_BITS-1:0] table_q [ENTRIES];
    logic [CTR_BITS-1:0] table_d [ENTRIES];
    logic [IDX_W-1:0]    ghr_q, ghr_d;
    logic [31:0]         br_count_q, br_count_d;
    logic [31:0]         mis_count_q, mis_count_d;

    logic [IDX_W-1:0]    lkp_idx;
    logic [IDX_W-1:0]    upd_idx;
    logic [IDX_W-1:0]    ghr_shift;
    logic [CTR_BITS-1:0] upd_ctr;
    logic                is_branch;
    logic                upd_pc_unused;

    // Only the word-index bits of the update PC select an entry.
    assign upd_pc_unused = ^upd_pc;

    generate
        if (IDX_W == 1) begin : g_ghr_one
            assign ghr_shift = upd_taken;
        end else begin : g_ghr_wide
            assign ghr_shift = {ghr_q[IDX_W-2:0], upd_taken};
        end
    endgenerate

    always_comb begin
        lkp_idx = pc[IDX_W+1:2];
        upd_idx = upd_pc[IDX_W+1:2];
        if (MODE == 1) begin
            lkp_idx = pc[IDX_W+1:2] ^ ghr_q;
            upd_idx = upd_pc[IDX_W+1:2] ^ upd_ghr;
        end
    end

    always_comb begin
        is_branch  = (opcode == OP_BRANCH) && !reset;
        branch     = is_branch;
        taken      = reset ? CTR_INIT : table_q[lkp_idx];
        pred_taken = is_branch & taken[CTR_BITS-1];
        b_pc       = is_branch ? pc : '0;
        ghr        = ghr_q;
        br_count   = br_count_q;
        mis_count  = mis_count_q;
    end

    always_comb begin
        table_d     = table_q;
        ghr_d       = ghr_q;
        br_count_d  = br_count_q;
        mis_count_d = mis_count_q;
        upd_ctr     = table_q[upd_idx];
        if (upd_valid) begin
            if (upd_taken) begin
                if (upd_ctr != CTR_MAX) upd_ctr = upd_ctr + CTR_BITS'(1);
            end else begin
                if (upd_ctr != '0) upd_ctr = upd_ctr - CTR_BITS'(1);
            end
            table_d[upd_idx] = upd_ctr;
            ghr_d            = ghr_shift;
            br_count_d       = br_count_q + 32'd1;
            mis_count_d      = mis_count_q + 32'(upd_mispredict);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) table_q[i] <= CTR_INIT;
            ghr_q       <= '0;
            br_count_q  <= '0;
            mis_count_q <= '0;
        end else begin
            table_q     <= table_d;
            ghr_q       <= ghr_d;
            br_count_q  <= br_count_d;
            mis_count_q <= mis_count_d;
        end
    end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed bench: a bimodal and a gshare instance share stimulus; each step checks hand-computed values.
module tb_branch_predictor_bht;

    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_ALU = 7'b0110011;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic [31:0] pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [3:0]  upd_ghr;
    logic        upd_taken;
    logic        upd_mispredict;

    logic        b_branch, g_branch;
    logic [1:0]  b_taken, g_taken;
    logic        b_pred, g_pred;
    logic [31:0] b_bpc, g_bpc;
    logic [3:0]  b_ghr, g_ghr;
    logic [31:0] b_br, g_br, b_mis, g_mis;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    branch_predictor_bht #(.PC_W(32), .IDX_W(4), .CTR_BITS(2), .INIT_STATE(1), .MODE(0)) u_bim (
        .clk(clk), .reset(reset), .opcode(opcode), .pc(pc),
        .branch(b_branch), .taken(b_taken), .pred_taken(b_pred), .b_pc(b_bpc), .ghr(b_ghr),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr), .upd_taken(upd_taken),
        .upd_mispredict(upd_mispredict), .br_count(b_br), .mis_count(b_mis)
    );

    branch_predictor_bht #(.PC_W(32), .IDX_W(4), .CTR_BITS(2), .INIT_STATE(1), .MODE(1)) u_gsh (
        .clk(clk), .reset(reset), .opcode(opcode), .pc(pc),
        .branch(g_branch), .taken(g_taken), .pred_taken(g_pred), .b_pc(g_bpc), .ghr(g_ghr),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr), .upd_taken(upd_taken),
        .upd_mispredict(upd_mispredict), .br_count(g_br), .mis_count(g_mis)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; opcode = OP_BR; pc = 32'h40;
        upd_valid = 1'b0; upd_pc = '0; upd_ghr = '0; upd_taken = 1'b0; upd_mispredict = 1'b0;
        tick();
        tick();
        chk("rst_branch", 32'(b_branch), 32'd0);
        chk("rst_bpc", b_bpc, 32'd0);
        chk("rst_taken", 32'(b_taken), 32'd1);
        chk("rst_pred", 32'(b_pred), 32'd0);
        chk("rst_ghr", 32'(b_ghr), 32'd0);
        chk("rst_br", b_br, 32'd0);
        chk("rst_mis", b_mis, 32'd0);
        reset = 1'b0;
        tick();

        // Plain lookups
        chk("lk_branch", 32'(b_branch), 32'd1);
        chk("lk_taken", 32'(b_taken), 32'd1);
        chk("lk_pred", 32'(b_pred), 32'd0);
        chk("lk_bpc", b_bpc, 32'h40);
        opcode = OP_ALU;
        #1;
        chk("alu_branch", 32'(b_branch), 32'd0);
        chk("alu_bpc", b_bpc, 32'd0);
        chk("alu_pred", 32'(b_pred), 32'd0);
        chk("alu_taken", 32'(b_taken), 32'd1);
        opcode = OP_BR;

        // Saturate up, then down
        upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1;
        tick(); chk("inc1", 32'(b_taken), 32'd2); chk("inc1_pred", 32'(b_pred), 32'd1);
        tick(); chk("inc2", 32'(b_taken), 32'd3);
        tick(); chk("inc3_sat", 32'(b_taken), 32'd3);
        upd_taken = 1'b0;
        tick(); chk("dec1", 32'(b_taken), 32'd2);
        tick(); chk("dec2", 32'(b_taken), 32'd1); chk("dec2_pred", 32'(b_pred), 32'd0);
        tick(); chk("dec3", 32'(b_taken), 32'd0);
        tick(); chk("dec4_sat", 32'(b_taken), 32'd0);
        upd_valid = 1'b0;
        pc = 32'h80;
        #1; chk("alias_0x80", 32'(b_taken), 32'd0);

        // Same-cycle update and lookup: no bypass
        pc = 32'h44; upd_valid = 1'b1; upd_pc = 32'h44; upd_taken = 1'b1;
        #1; chk("same_cyc_old", 32'(b_taken), 32'd1);
        tick();
        upd_valid = 1'b0;
        chk("same_cyc_new", 32'(b_taken), 32'd2);
        chk("br_after_8", b_br, 32'd8);

        // Statistics from a clean start
        reset = 1'b1; tick(); reset = 1'b0;
        chk("stat_rst_br", b_br, 32'd0);
        for (int i = 0; i < 10; i++) begin
            upd_valid = 1'b1; upd_pc = 32'h48; upd_ghr = 4'h0; upd_taken = 1'b1;
            upd_mispredict = (i == 0 || i == 3 || i == 5 || i == 9);
            tick();
        end
        upd_valid = 1'b0; upd_mispredict = 1'b1;
        tick(); tick();
        upd_mispredict = 1'b0;
        chk("stat_br", b_br, 32'd10);
        chk("stat_mis", b_mis, 32'd4);
        chk("stat_ghr", 32'(b_ghr), 32'hF);
        pc = 32'h48;
        #1; chk("stat_ctr", 32'(b_taken), 32'd3);

        // Reset wins over a concurrent update
        reset = 1'b1; upd_valid = 1'b1; upd_pc = 32'h48; upd_taken = 1'b1; upd_mispredict = 1'b1;
        #1;
        chk("midrst_branch", 32'(b_branch), 32'd0);
        chk("midrst_taken", 32'(b_taken), 32'd1);
        tick();
        reset = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0;
        #1;
        chk("midrst_ctr", 32'(b_taken), 32'd1);
        chk("midrst_br", b_br, 32'd0);
        chk("midrst_mis", b_mis, 32'd0);
        chk("midrst_ghr", 32'(b_ghr), 32'd0);
        chk("midrst_gghr", 32'(g_ghr), 32'd0);

        // Gshare history and indexing
        upd_valid = 1'b1; upd_pc = 32'h0; upd_ghr = 4'h0;
        upd_taken = 1'b1; tick(); chk("gs_ghr1", 32'(g_ghr), 32'h1);
        upd_taken = 1'b1; tick(); chk("gs_ghr2", 32'(g_ghr), 32'h3);
        upd_taken = 1'b0; tick(); chk("gs_ghr3", 32'(g_ghr), 32'h6);
        upd_pc = 32'h10; upd_ghr = 4'b0011; upd_taken = 1'b1;
        tick(); chk("gs_ghr4", 32'(g_ghr), 32'hD);
        upd_valid = 1'b0;
        pc = 32'h28;
        #1; chk("gs_lk_0x28", 32'(g_taken), 32'd2);
        pc = 32'h1C;
        #1; chk("gs_lk_0x1c_other", 32'(g_taken), 32'd1);
        upd_valid = 1'b1; upd_pc = 32'h3C; upd_ghr = 4'h0; upd_taken = 1'b0;
        repeat (4) tick();
        upd_valid = 1'b0;
        chk("gs_ghr_zero", 32'(g_ghr), 32'h0);
        chk("gs_lk_0x1c", 32'(g_taken), 32'd2);
        chk("gs_pred_0x1c", 32'(g_pred), 32'd1);
        chk("gs_br", g_br, 32'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
